// File: rtl/axi_sram_rd_slave_if.sv
// axi_sram_rd_slave_if: AR/R channel and SRAM port bundle for axi_sram_rd_slave
interface axi_sram_rd_slave_if #(
  parameter int IDS_W = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SRAM_AW = 14
);
  logic [IDS_W-1:0] arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, arready;
  logic [IDS_W-1:0] rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0] rresp;
  logic rlast, rvalid, rready;
  logic sram_cs;
  logic [SRAM_AW-1:0] sram_a;
  logic [DATA_W-1:0] sram_do;
  modport slave (
    input arid, araddr, arlen, arsize, arburst, arvalid, rready, sram_do,
    output arready, rid, rdata, rresp, rlast, rvalid, sram_cs, sram_a
  );
  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready, sram_do,
    input arready, rid, rdata, rresp, rlast, rvalid, sram_cs, sram_a
  );
endinterface

// File: rtl/axi_sram_rd_slave.sv
// axi_sram_rd_slave: AXI4 read slave over a 1-cycle-latency SRAM, one burst in flight.
// Define AXI_RD_PERF_CNT_EN to add saturating beat/stall counters.
module axi_sram_rd_slave #(
  parameter int IDS_W = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int SRAM_AW = 14
) (
  input logic clk,
  input logic rst,
  axi_sram_rd_slave_if.slave bus
`ifdef AXI_RD_PERF_CNT_EN
  ,
  output logic [31:0] perf_beats,
  output logic [31:0] perf_stall
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t state, state_nxt;
  logic [IDS_W-1:0] id;
  logic [SRAM_AW-1:0] addr, addr_nxt, mask;
  logic [3:0] len, cnt;
  logic [1:0] burst;
  logic err, err_req, ar_hs, r_hs;
  assign ar_hs = rst && state == IDLE && bus.arvalid;
  assign r_hs = bus.rvalid && bus.rready;
  assign err_req = bus.arsize != 3'b010 || bus.arburst == 2'b11 ||
                   (bus.arburst == 2'b10 && !(bus.arlen inside {4'd1, 4'd3, 4'd7, 4'd15}));
  assign mask = SRAM_AW'(len);
  assign bus.rid = id;
  // WRAP containers are power-of-two sized, so len doubles as the low-bit mask
  assign addr_nxt = burst == 2'b00 ? addr :
                    burst == 2'b10 ? (addr & ~mask) | ((addr + SRAM_AW'(1)) & mask) :
                    addr + SRAM_AW'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (ar_hs ? FETCH : IDLE) :
                state == FETCH ? DATA :
                state == DATA ? (r_hs ? (bus.rlast ? IDLE : FETCH) : DATA) : IDLE;
  always_comb begin
    bus.arready = rst && state == IDLE;
    bus.sram_cs = (ar_hs && !err_req) || (rst && state == DATA && r_hs && !bus.rlast && !err);
    bus.sram_a = !rst ? '0 : state == IDLE ? bus.araddr[SRAM_AW+1:2] : addr_nxt;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      id <= '0;
      addr <= '0;
      len <= '0;
      burst <= '0;
      err <= 1'b0;
      cnt <= '0;
      bus.rdata <= '0;
      bus.rresp <= '0;
      bus.rlast <= 1'b0;
      bus.rvalid <= 1'b0;
    end else begin
      if (ar_hs) begin
        id <= bus.arid;
        addr <= bus.araddr[SRAM_AW+1:2];
        len <= bus.arlen;
        burst <= bus.arburst;
        err <= err_req;
        cnt <= '0;
      end
      if (state == FETCH) begin
        bus.rdata <= err ? '0 : bus.sram_do;
        bus.rvalid <= 1'b1;
        bus.rlast <= cnt == len;
        bus.rresp <= err ? 2'b10 : 2'b00;
      end
      if (state == DATA && r_hs) begin
        bus.rvalid <= 1'b0;
        if (!bus.rlast) begin
          cnt <= cnt + 4'd1;
          addr <= addr_nxt;
        end
      end
    end
`ifdef AXI_RD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      perf_beats <= '0;
      perf_stall <= '0;
    end else begin
      if (r_hs && perf_beats != '1) perf_beats <= perf_beats + 32'd1;
      if (bus.rvalid && !bus.rready && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// tb_axi_sram_rd_slave: directed scoreboard bench for axi_sram_rd_slave
module tb_axi_sram_rd_slave;
  typedef struct packed {logic [7:0] id; logic [31:0] d; logic [1:0] r; logic l;} beat_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n = 0, fails = 0, cyc = 0, t_ar = 0;
  beat_t bq[$];
  logic [13:0] aq[$];
  axi_sram_rd_slave_if #(.IDS_W(8), .DATA_W(32), .ADDR_W(32), .SRAM_AW(14)) bus ();
`ifdef AXI_RD_PERF_CNT_EN
  logic [31:0] perf_beats, perf_stall;
  axi_sram_rd_slave dut (.clk(clk), .rst(rst), .bus(bus), .perf_beats(perf_beats), .perf_stall(perf_stall));
`else
  axi_sram_rd_slave dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [31:0] mem_val(input logic [13:0] w);
    return {16'hA000, 2'b00, w};
  endfunction
  always @(posedge clk) if (bus.sram_cs === 1'b1) bus.sram_do <= mem_val(bus.sram_a);
  // WRAP stepping modelled on byte addresses inside an aligned container
  function automatic logic [13:0] step(input logic [13:0] w, input int len, input logic [1:0] burst);
    int sz, ba, base;
    if (burst == 2'b00) return w;
    if (burst == 2'b01) return w + 14'd1;
    sz = (len + 1) * 4;
    ba = int'(w) * 4;
    base = ba - ba % sz;
    return 14'((base + (ba + 4 - base) % sz) / 4);
  endfunction
  always @(negedge clk) if (bus.sram_cs === 1'b1) begin
    logic [13:0] ea;
    n++;
    assert (aq.size() != 0) else begin fails++; $error("FAIL sram_cs unexpected a=%h required no read", bus.sram_a); end
    if (aq.size() != 0) begin
      ea = aq.pop_front();
      n++;
      assert (bus.sram_a === ea) else begin fails++; $error("FAIL sram_a got %h required %h", bus.sram_a, ea); end
    end
  end
  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    logic e;
    logic [13:0] w;
    int k;
    e = size != 3'b010 || burst == 2'b11 || (burst == 2'b10 && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    w = addr[15:2];
    for (int i = 0; i <= int'(len); i++) begin
      if (!e) aq.push_back(w);
      bq.push_back('{id, e ? 32'h0 : mem_val(w), e ? 2'b10 : 2'b00, i == int'(len)});
      w = step(w, int'(len), burst);
    end
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    k = 0;
    @(negedge clk);
    while (bus.arready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n++;
    assert (bus.arready === 1'b1) else begin fails++; $error("FAIL ar_accept arready=%b required 1", bus.arready); end
    t_ar = cyc;
    @(posedge clk) #1 bus.arvalid = 1'b0;
  endtask
  task automatic recv(input int nb, input int stall_at, input int stall_n, input bit timed);
    beat_t got, exp, hold;
    int k;
    bit ok;
    for (int b = 0; b < nb; b++) begin
      bus.rready = (b != stall_at);
      k = 0;
      @(negedge clk);
      while (bus.rvalid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (b == stall_at) begin
        hold = '{bus.rid, bus.rdata, bus.rresp, bus.rlast};
        for (int s = 0; s < stall_n; s++) begin
          got = '{bus.rid, bus.rdata, bus.rresp, bus.rlast};
          n++;
          assert (bus.rvalid === 1'b1 && got === hold && bus.sram_cs === 1'b0)
            else begin fails++; $error("FAIL stall_hold cyc %0d rvalid=%b beat=%h cs=%b required 1/%h/0", s, bus.rvalid, got, bus.sram_cs, hold); end
          @(posedge clk);
          if (s == stall_n - 1) #1 bus.rready = 1'b1;
          @(negedge clk);
        end
      end
      got = '{bus.rid, bus.rdata, bus.rresp, bus.rlast};
      ok = bq.size() != 0;
      exp = '0;
      if (ok) exp = bq.pop_front();
      n++;
      assert (bus.rvalid === 1'b1 && ok && got === exp)
        else begin fails++; $error("FAIL beat%0d rvalid=%b got %h required %h", b, bus.rvalid, got, exp); end
      n++;
      assert (bus.arready === 1'b0) else begin fails++; $error("FAIL arready_busy got %b required 0", bus.arready); end
      if (timed) begin
        n++;
        assert (cyc === t_ar + 2 + 2 * b) else begin fails++; $error("FAIL beat%0d_time got %0d required %0d", b, cyc - t_ar, 2 + 2 * b); end
      end
      @(posedge clk) #1;
    end
  endtask
  initial begin
    int k;
    bus.arvalid = 1'b0; bus.rready = 1'b1; bus.arid = '0; bus.araddr = '0;
    bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    repeat (2) @(negedge clk);
    n++;
    assert ({bus.arready, bus.rvalid, bus.rlast, bus.sram_cs, bus.rid, bus.rdata, bus.rresp, bus.sram_a} === '0)
      else begin fails++; $error("FAIL reset_outs got %h required 0", {bus.arready, bus.rvalid, bus.rlast, bus.sram_cs, bus.rid, bus.rdata, bus.rresp, bus.sram_a}); end
    @(posedge clk) #1 rst = 1'b1;
    @(negedge clk);
    n++;
    assert (bus.arready === 1'b1) else begin fails++; $error("FAIL arready_after_reset got %b required 1", bus.arready); end
    @(posedge clk) #1;
    send_ar(8'h15, 32'h100, 4'd3, 3'b010, 2'b01);
    recv(4, -1, 0, 1'b1);
    @(negedge clk);
    n++;
    assert (bus.arready === 1'b1 && cyc === t_ar + 9)
      else begin fails++; $error("FAIL arready_return got %b at +%0d required 1 at +9", bus.arready, cyc - t_ar); end
    @(posedge clk) #1;
    send_ar(8'h15, 32'h100, 4'd3, 3'b010, 2'b01);
    recv(4, 1, 5, 1'b0);
`ifdef AXI_RD_PERF_CNT_EN
    n++;
    assert (perf_stall === 32'd5 && perf_beats === 32'd8)
      else begin fails++; $error("FAIL perf got stall=%0d beats=%0d required 5/8", perf_stall, perf_beats); end
`endif
    send_ar(8'h2A, 32'h18, 4'd3, 3'b010, 2'b10);
    recv(4, -1, 0, 1'b1);
    send_ar(8'h03, 32'h20, 4'd2, 3'b010, 2'b00);
    recv(3, -1, 0, 1'b1);
    send_ar(8'h7E, 32'hFFF8, 4'd3, 3'b010, 2'b01);
    recv(4, -1, 0, 1'b1);
    send_ar(8'h41, 32'h40, 4'd1, 3'b011, 2'b01);
    recv(2, -1, 0, 1'b1);
    send_ar(8'h42, 32'h40, 4'd1, 3'b010, 2'b11);
    recv(2, -1, 0, 1'b1);
    send_ar(8'h43, 32'h40, 4'd2, 3'b010, 2'b10);
    recv(3, -1, 0, 1'b1);
    send_ar(8'h55, 32'h100, 4'd3, 3'b010, 2'b01);
    recv(1, -1, 0, 1'b1);
    bus.rready = 1'b0;
    k = 0;
    @(negedge clk);
    while (bus.rvalid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    @(posedge clk) #1 rst = 1'b0;
    #1;
    n++;
    assert (bus.rvalid === 1'b0 && bus.rlast === 1'b0 && bus.arready === 1'b0)
      else begin fails++; $error("FAIL midburst_reset rvalid=%b rlast=%b arready=%b required 0/0/0", bus.rvalid, bus.rlast, bus.arready); end
    bq.delete();
    aq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    bus.rready = 1'b1;
    @(negedge clk);
    n++;
    assert (bus.arready === 1'b1) else begin fails++; $error("FAIL arready_post_reset got %b required 1", bus.arready); end
    @(posedge clk) #1;
    send_ar(8'h66, 32'h44, 4'd0, 3'b010, 2'b01);
    recv(1, -1, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n++;
      assert (bus.rvalid === 1'b0) else begin fails++; $error("FAIL extra_beat cyc %0d rvalid=%b required 0", i, bus.rvalid); end
    end
    n++;
    assert (aq.size() == 0 && bq.size() == 0)
      else begin fails++; $error("FAIL leftover reads=%0d beats=%0d required 0/0", aq.size(), bq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n, fails);
    $finish;
  end
endmodule
